// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single Data_Memory port between the instruction cache (m0) and
// the data cache (m1). A winning request is latched into the mem_* registers
// and held stable until the memory acknowledges it. The ack is forwarded only
// to the winner. Ties are resolved round-robin against the last granted
// port. Each port has a saturating grant counter for performance reporting.
//
// Ports
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   m0_* / m1_*           requester ports: enable/write/addr/data in, ack out
//   rd_data_o             memory read data, broadcast to both requesters
//   mem_*_o               request to Data_Memory (enable/write/addr/data)
//   mem_ack_i, mem_data_i Data_Memory completion pulse and read data
//   busy_o                a transaction is outstanding
//   grant_id_o            port currently or last granted
//   m0_grants_o           saturating count of grants issued to m0
//   m1_grants_o           saturating count of grants issued to m1
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,

    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,

    output logic [DATA_W-1:0] rd_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,

    output logic              busy_o,
    output logic              grant_id_o,
    output logic [CNT_W-1:0]  m0_grants_o,
    output logic [CNT_W-1:0]  m1_grants_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]        state_q,      state_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q,  mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_data_q,   mem_data_d;
    logic              grant_id_q,   grant_id_d;
    logic [CNT_W-1:0]  m0_cnt_q,     m0_cnt_d;
    logic [CNT_W-1:0]  m1_cnt_q,     m1_cnt_d;

    logic winner;
    logic is_busy;

    assign is_busy = (state_q == ST_BUSY);

    // m1 wins when it is the only requester, or when both request and m0
    // was the last port served; otherwise m0 wins.
    assign winner = m1_enable_i & (~m0_enable_i | ~grant_id_q);

    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        grant_id_d   = grant_id_q;
        m0_cnt_d     = m0_cnt_q;
        m1_cnt_d     = m1_cnt_q;

        if (state_q == ST_IDLE) begin
            if (m0_enable_i || m1_enable_i) begin
                state_d      = ST_BUSY;
                mem_enable_d = 1'b1;
                grant_id_d   = winner;
                if (winner) begin
                    mem_write_d = m1_write_i;
                    mem_addr_d  = m1_addr_i;
                    mem_data_d  = m1_data_i;
                    if (m1_cnt_q != CNT_MAX) begin
                        m1_cnt_d = m1_cnt_q + CNT_W'(1);
                    end
                end else begin
                    mem_write_d = m0_write_i;
                    mem_addr_d  = m0_addr_i;
                    mem_data_d  = m0_data_i;
                    if (m0_cnt_q != CNT_MAX) begin
                        m0_cnt_d = m0_cnt_q + CNT_W'(1);
                    end
                end
            end
        end else begin
            // Requester inputs are ignored here; only the memory ack ends the
            // transaction. Address and data stay on the bus after completion.
            if (mem_ack_i) begin
                state_d      = ST_IDLE;
                mem_enable_d = 1'b0;
                mem_write_d  = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            grant_id_q   <= 1'b1;   // makes m0 win the first tie
            m0_cnt_q     <= '0;
            m1_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            grant_id_q   <= grant_id_d;
            m0_cnt_q     <= m0_cnt_d;
            m1_cnt_q     <= m1_cnt_d;
        end
    end

    // An ack seen while idle is stray and is never forwarded.
    assign m0_ack_o = is_busy & mem_ack_i & ~grant_id_q;
    assign m1_ack_o = is_busy & mem_ack_i &  grant_id_q;

    assign rd_data_o    = mem_data_i;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign busy_o       = is_busy;
    assign grant_id_o   = grant_id_q;
    assign m0_grants_o  = m0_cnt_q;
    assign m1_grants_o  = m1_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Requesters and a Data_Memory model are
// driven on the falling edge. A transaction-level reference model checks
// every DUT output each cycle. Directed scenarios also check hand-computed
// literal results: grant order, memory contents, counters and read data.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int DW      = 256;
    localparam int AW      = 32;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          m0_enable_i = 1'b0, m0_write_i = 1'b0;
    logic [AW-1:0] m0_addr_i = '0;
    logic [DW-1:0] m0_data_i = '0;
    logic          m0_ack_o;
    logic          m1_enable_i = 1'b0, m1_write_i = 1'b0;
    logic [AW-1:0] m1_addr_i = '0;
    logic [DW-1:0] m1_data_i = '0;
    logic          m1_ack_o;
    logic [DW-1:0] rd_data_o;
    logic          mem_enable_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_data_i = '0;
    logic          busy_o, grant_id_o;
    logic [CW-1:0] m0_grants_o, m1_grants_o;

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o),
        .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o),
        .rd_data_o(rd_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .busy_o(busy_o), .grant_id_o(grant_id_o),
        .m0_grants_o(m0_grants_o), .m1_grants_o(m1_grants_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    function automatic req_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_t r;
        r.write = w;
        r.addr  = a;
        r.data  = d;
        return r;
    endfunction

    // Written by the main sequence only.
    req_t          req0[$], req1[$];
    int            mem_lat  = 2;
    int            stale_req = 0;
    int            ovr_req   = 0;
    logic [AW-1:0] ovr_addr  = '0;
    logic [DW-1:0] ovr_data  = '0;

    // Written by the environment process only.
    int            ptr0 = 0, ptr1 = 0;
    bit            drop0 = 0, drop1 = 0;
    int            wait_cnt = 0;
    int            stale_done = 0, ovr_done = 0;
    int            ack0_n = 0, ack1_n = 0;
    logic [DW-1:0] last_rd0 = '0, last_rd1 = '0;
    logic [DW-1:0] mem [8];

    // ---------------------------------------------------------------------
    // Requesters and Data_Memory, all driven on the falling edge. A
    // requester keeps enable high until it sees its ack, drops it for one
    // cycle, then presents its next queued request.
    // ---------------------------------------------------------------------
    always @(negedge clk_i) begin
        if (rst_i) begin
            mem_ack_i   = 1'b0;
            wait_cnt    = 0;
            m0_enable_i = 1'b0;
            m1_enable_i = 1'b0;
            drop0       = 0;
            drop1       = 0;
            ptr0        = req0.size();
            ptr1        = req1.size();
            ack0_n      = 0;
            ack1_n      = 0;
            stale_done  = stale_req;
            for (int i = 0; i < 8; i++) mem[i] = 256'hDEAD_0000 + DW'(i);
        end else begin
            if (drop0) begin
                m0_enable_i = 1'b0;
                drop0       = 0;
                ptr0++;
            end else if (!m0_enable_i && ptr0 < req0.size()) begin
                m0_write_i  = req0[ptr0].write;
                m0_addr_i   = req0[ptr0].addr;
                m0_data_i   = req0[ptr0].data;
                m0_enable_i = 1'b1;
            end
            if (drop1) begin
                m1_enable_i = 1'b0;
                drop1       = 0;
                ptr1++;
            end else if (!m1_enable_i && ptr1 < req1.size()) begin
                m1_write_i  = req1[ptr1].write;
                m1_addr_i   = req1[ptr1].addr;
                m1_data_i   = req1[ptr1].data;
                m1_enable_i = 1'b1;
            end
            if (ovr_req != ovr_done) begin
                m1_addr_i = ovr_addr;
                m1_data_i = ovr_data;
                ovr_done  = ovr_req;
            end

            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                wait_cnt  = 0;
            end else if (stale_req != stale_done) begin
                mem_ack_i  = 1'b1;
                stale_done = stale_req;
            end else if (mem_enable_o) begin
                wait_cnt++;
                if (wait_cnt >= mem_lat) begin
                    if (mem_write_o) mem[int'(mem_addr_o[7:5])] = mem_data_o;
                    else             mem_data_i = mem[int'(mem_addr_o[7:5])];
                    mem_ack_i = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end

            #1;
            if (m0_ack_o) begin drop0 = 1; last_rd0 = rd_data_o; ack0_n++; end
            if (m1_ack_o) begin drop1 = 1; last_rd1 = rd_data_o; ack1_n++; end
        end
    end

    // ---------------------------------------------------------------------
    // Reference model: one outstanding transaction record, a grant log and
    // per-port grant totals, advanced once per rising edge from the inputs.
    // ---------------------------------------------------------------------
    int   n_vec_c = 0, n_err_c = 0;
    bit   mdl_busy = 0;
    int   mdl_gid  = 1;
    int   mdl_cnt [2] = '{0, 0};
    req_t mdl_cur;
    int   mdl_log[$];

    task automatic cchk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_vec_c++;
        if (act !== req) begin
            n_err_c++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    always begin
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            mdl_busy   = 0;
            mdl_gid    = 1;
            mdl_cnt[0] = 0;
            mdl_cnt[1] = 0;
            mdl_cur    = mk(1'b0, '0, '0);
            mdl_log.delete();
        end else if (!mdl_busy) begin
            if (m0_enable_i || m1_enable_i) begin
                int w;
                if (m0_enable_i && m1_enable_i) w = 1 - mdl_gid;
                else                            w = m0_enable_i ? 0 : 1;
                mdl_cur = (w == 0) ? mk(m0_write_i, m0_addr_i, m0_data_i)
                                   : mk(m1_write_i, m1_addr_i, m1_data_i);
                mdl_busy = 1;
                mdl_gid  = w;
                if (mdl_cnt[w] < CNT_MAX) mdl_cnt[w]++;
                mdl_log.push_back(w);
            end
        end else if (mem_ack_i) begin
            mdl_busy = 0;
        end
        cchk("busy",       DW'(busy_o),       DW'(mdl_busy));
        cchk("mem_enable", DW'(mem_enable_o), DW'(mdl_busy));
        cchk("mem_write",  DW'(mem_write_o),  DW'(mdl_busy && mdl_cur.write));
        cchk("mem_addr",   DW'(mem_addr_o),   DW'(mdl_cur.addr));
        cchk("mem_data",   mem_data_o,        mdl_cur.data);
        cchk("grant_id",   DW'(grant_id_o),   DW'(mdl_gid));
        cchk("m0_grants",  DW'(m0_grants_o),  DW'(mdl_cnt[0]));
        cchk("m1_grants",  DW'(m1_grants_o),  DW'(mdl_cnt[1]));

        @(negedge clk_i);
        #2;
        if (!rst_i) begin
            cchk("m0_ack",  DW'(m0_ack_o), DW'(mdl_busy && mem_ack_i && mdl_gid == 0));
            cchk("m1_ack",  DW'(m1_ack_o), DW'(mdl_busy && mem_ack_i && mdl_gid == 1));
            cchk("rd_data", rd_data_o, mem_data_i);
        end
    end

    // ---------------------------------------------------------------------
    // Directed scenarios with literal expectations
    // ---------------------------------------------------------------------
    int n_vec_m = 0, n_err_m = 0;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_vec_m++;
        if (act !== req) begin
            n_err_m++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            #3;
            if (ptr0 == req0.size() && ptr1 == req1.size() &&
                !m0_enable_i && !m1_enable_i && !busy_o) begin
                ok = 1;
                break;
            end
        end
        check(nm, DW'(ok), DW'(1));
    endtask

    task automatic wait_busy(input string nm, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (busy_o) break;
        end
        check(nm, DW'(busy_o), DW'(1));
    endtask

    initial begin
        int exp_order [6] = '{0, 1, 0, 1, 0, 1};
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_mem_enable", DW'(mem_enable_o), DW'(0));
        check("rst_mem_write",  DW'(mem_write_o),  DW'(0));
        check("rst_mem_addr",   DW'(mem_addr_o),   DW'(0));
        check("rst_mem_data",   mem_data_o,        DW'(0));
        check("rst_busy",       DW'(busy_o),       DW'(0));
        check("rst_grant_id",   DW'(grant_id_o),   DW'(1));
        check("rst_m0_grants",  DW'(m0_grants_o),  DW'(0));
        check("rst_m1_grants",  DW'(m1_grants_o),  DW'(0));
        rst_i = 1'b0;

        // Single m1 read with a 10-cycle memory.
        do_reset();
        mem_lat = 10;
        req1.push_back(mk(1'b0, 32'h20, '0));
        @(negedge clk_i);
        #2;
        check("t1_not_yet_granted", DW'(mem_enable_o), DW'(0));
        @(posedge clk_i);
        #1;
        check("t1_enable",    DW'(mem_enable_o), DW'(1));
        check("t1_addr",      DW'(mem_addr_o),   DW'(32'h20));
        check("t1_write",     DW'(mem_write_o),  DW'(0));
        check("t1_grant_id",  DW'(grant_id_o),   DW'(1));
        wait_done("t1_drain", 100);
        check("t1_rd_data",   last_rd1,          256'hDEAD_0001);
        check("t1_m1_acks",   DW'(ack1_n),       DW'(1));
        check("t1_m0_acks",   DW'(ack0_n),       DW'(0));
        check("t1_m1_grants", DW'(m1_grants_o),  DW'(1));
        check("t1_m0_grants", DW'(m0_grants_o),  DW'(0));

        // Simultaneous requests straight out of reset.
        do_reset();
        mem_lat = 2;
        req0.push_back(mk(1'b0, 32'h00, '0));
        req1.push_back(mk(1'b1, 32'h40, 256'hAB));
        wait_done("t2_drain", 100);
        check("t2_grants",    DW'(mdl_log.size()), DW'(2));
        check("t2_first",     DW'(mdl_log[0]),     DW'(0));
        check("t2_second",    DW'(mdl_log[1]),     DW'(1));
        check("t2_mem2",      mem[2],              256'hAB);
        check("t2_rd0",       last_rd0,            256'hDEAD_0000);
        check("t2_m0_grants", DW'(m0_grants_o),    DW'(1));
        check("t2_m1_grants", DW'(m1_grants_o),    DW'(1));

        // Both ports busy for six transactions: strict alternation.
        do_reset();
        mem_lat = 2;
        for (int i = 0; i < 3; i++) begin
            req0.push_back(mk(1'b0, AW'(32 * i), '0));
            req1.push_back(mk(1'b0, AW'(32 * (i + 4)), '0));
        end
        wait_done("t3_drain", 200);
        check("t3_grants", DW'(mdl_log.size()), DW'(6));
        for (int i = 0; i < 6 && i < mdl_log.size(); i++)
            check($sformatf("t3_order%0d", i), DW'(mdl_log[i]), DW'(exp_order[i]));
        check("t3_m0_grants", DW'(m0_grants_o), DW'(3));
        check("t3_m1_grants", DW'(m1_grants_o), DW'(3));

        // Requester changes address and data while its write is in flight.
        do_reset();
        mem_lat = 5;
        req1.push_back(mk(1'b1, 32'h60, 256'h5555));
        wait_busy("t4_busy", 50);
        @(posedge clk_i);
        #1;
        ovr_addr = 32'h80;
        ovr_data = 256'h9999;
        ovr_req++;
        @(posedge clk_i);
        #1;
        check("t4_addr_held", DW'(mem_addr_o), DW'(32'h60));
        check("t4_data_held", mem_data_o,      256'h5555);
        wait_done("t4_drain", 100);
        check("t4_mem3",       mem[3],          256'h5555);
        check("t4_mem4",       mem[4],          256'hDEAD_0004);
        check("t4_addr_after", DW'(mem_addr_o), DW'(32'h60));

        // Reset three cycles into a transaction, then a stray memory ack.
        do_reset();
        mem_lat = 10;
        req0.push_back(mk(1'b0, 32'h00, '0));
        wait_busy("t5_busy", 50);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("t5_enable",    DW'(mem_enable_o), DW'(0));
        check("t5_busy_rst",  DW'(busy_o),       DW'(0));
        check("t5_m0_grants", DW'(m0_grants_o),  DW'(0));
        check("t5_grant_id",  DW'(grant_id_o),   DW'(1));
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        stale_req++;
        @(negedge clk_i);
        #2;
        check("t5_stale_m0_ack", DW'(m0_ack_o), DW'(0));
        check("t5_stale_m1_ack", DW'(m1_ack_o), DW'(0));
        @(posedge clk_i);
        #1;
        check("t5_stays_idle", DW'(busy_o), DW'(0));
        check("t5_no_enable",  DW'(mem_enable_o), DW'(0));

        // Twenty m0 grants against a 4-bit counter.
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 20; i++) req0.push_back(mk(1'b0, AW'(32 * (i % 8)), '0));
        wait_done("t6_drain", 400);
        check("t6_grants",    DW'(mdl_log.size()), DW'(20));
        check("t6_m0_acks",   DW'(ack0_n),         DW'(20));
        check("t6_m0_sat",    DW'(m0_grants_o),    DW'(15));
        check("t6_m1_grants", DW'(m1_grants_o),    DW'(0));

        repeat (2) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec_m + n_vec_c, n_err_m + n_err_c);
        $finish;
    end

endmodule
